// File: rtl/test_result_uart_tx_if.sv
// rtl/test_result_uart_tx_if.sv - core-status inputs and UART report outputs of the result reporter
//
// Purpose: bundles the regfile taps (x26/x27/x3) and the reporter's outputs.
// Signals:
//   done_i        32  x26 value, finished when exactly 1
//   pass_i        32  x27 value, pass when exactly 1
//   test_num_i    32  x3 value, low byte reported on fail
//   uart_tx_o     1   8N1 serial line, idle high
//   busy_o        1   high from done detection until the last stop bit ends
//   report_done_o 1   high once the message is fully sent, held until reset
//   result_o      1   latched verdict, 1 = pass
// Modports: master drives the core side, slave is the reporter.
interface test_result_uart_tx_if;
    logic [31:0] done_i;
    logic [31:0] pass_i;
    logic [31:0] test_num_i;
    logic        uart_tx_o;
    logic        busy_o;
    logic        report_done_o;
    logic        result_o;

    modport master (
        output done_i, pass_i, test_num_i,
        input  uart_tx_o, busy_o, report_done_o, result_o
    );

    modport slave (
        input  done_i, pass_i, test_num_i,
        output uart_tx_o, busy_o, report_done_o, result_o
    );
endinterface

// File: rtl/test_result_uart_tx.sv
// rtl/test_result_uart_tx.sv - one-shot riscv-tests pass/fail reporter over an 8N1 UART
//
// Purpose: waits for x26 == 1, lets the core settle for SETTLE_CYCLES clocks,
// latches the verdict (x27 == 1) and the low byte of x3, then sends
// "PASS\r\n" or "FAIL hh\r\n" once per reset.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   res_if slave side of test_result_uart_tx_if (inputs from the regfile,
//          uart_tx_o / busy_o / report_done_o / result_o outputs)
module test_result_uart_tx #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD          = 115200,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    test_result_uart_tx_if.slave  res_if
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   settle_cnt_q;
    logic [BW-1:0]   baud_cnt_q;
    logic [3:0]      bit_idx_q;
    logic [3:0]      byte_idx_q;
    logic [7:0]      tnum_q;
    logic            result_q;
    logic            tx_q;
    logic            busy_q;
    logic            report_done_q;

    logic [3:0]      msg_len_d;
    logic [7:0]      cur_byte_d;
    logic [7:0]      shifted_d;
    logic            tx_bit_d;
    logic            unused_tnum_hi;

    assign unused_tnum_hi = ^res_if.test_num_i[31:8];

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        msg_len_d  = result_q ? 4'd6 : 4'd9;
        cur_byte_d = 8'h0A;
        if (result_q) begin
            case (byte_idx_q)
                4'd0:    cur_byte_d = 8'h50;
                4'd1:    cur_byte_d = 8'h41;
                4'd2:    cur_byte_d = 8'h53;
                4'd3:    cur_byte_d = 8'h53;
                4'd4:    cur_byte_d = 8'h0D;
                default: cur_byte_d = 8'h0A;
            endcase
        end else begin
            case (byte_idx_q)
                4'd0:    cur_byte_d = 8'h46;
                4'd1:    cur_byte_d = 8'h41;
                4'd2:    cur_byte_d = 8'h49;
                4'd3:    cur_byte_d = 8'h4C;
                4'd4:    cur_byte_d = 8'h20;
                4'd5:    cur_byte_d = hex_ascii(tnum_q[7:4]);
                4'd6:    cur_byte_d = hex_ascii(tnum_q[3:0]);
                4'd7:    cur_byte_d = 8'h0D;
                default: cur_byte_d = 8'h0A;
            endcase
        end
        // Frame position 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
        shifted_d = cur_byte_d >> (bit_idx_q - 4'd1);
        if (bit_idx_q == 4'd0) begin
            tx_bit_d = 1'b0;
        end else if (bit_idx_q == 4'd9) begin
            tx_bit_d = 1'b1;
        end else begin
            tx_bit_d = shifted_d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            settle_cnt_q  <= '0;
            baud_cnt_q    <= '0;
            bit_idx_q     <= '0;
            byte_idx_q    <= '0;
            tnum_q        <= '0;
            result_q      <= 1'b0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            report_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (res_if.done_i == 32'd1) begin
                        state_q      <= S_SETTLE;
                        busy_q       <= 1'b1;
                        settle_cnt_q <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        result_q   <= (res_if.pass_i == 32'd1);
                        tnum_q     <= res_if.test_num_i[7:0];
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                        state_q    <= S_SEND;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                S_SEND: begin
                    // The line register trails the frame counters by one clock, so the
                    // counters run one slot past the last byte; that extra slot is the
                    // edge on which the final stop bit has fully elapsed.
                    if (byte_idx_q == msg_len_d) begin
                        state_q       <= S_DONE;
                        tx_q          <= 1'b1;
                        busy_q        <= 1'b0;
                        report_done_q <= 1'b1;
                    end else begin
                        tx_q <= tx_bit_d;
                        if (baud_cnt_q == BAUD_LAST) begin
                            baud_cnt_q <= '0;
                            if (bit_idx_q == 4'd9) begin
                                bit_idx_q  <= '0;
                                byte_idx_q <= byte_idx_q + 4'd1;
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                            end
                        end else begin
                            baud_cnt_q <= baud_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q          <= 1'b1;
                    report_done_q <= 1'b1;
                end
            endcase
        end
    end

    assign res_if.uart_tx_o     = tx_q;
    assign res_if.busy_o        = busy_q;
    assign res_if.report_done_o = report_done_q;
    assign res_if.result_o      = result_q;
endmodule

// File: tb/tb_test_result_uart_tx.sv
// tb/tb_test_result_uart_tx.sv - directed self-checking bench for test_result_uart_tx
module tb_test_result_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_msg [9];
    int   exp_len;
    int   t0;

    test_result_uart_tx_if bus();

    test_result_uart_tx #(
        .CLK_FREQ(1000),
        .BAUD(100),
        .SETTLE_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .res_if(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pass_msg();
        exp_len = 6;
        exp_msg[0] = 8'h50; exp_msg[1] = 8'h41; exp_msg[2] = 8'h53;
        exp_msg[3] = 8'h53; exp_msg[4] = 8'h0D; exp_msg[5] = 8'h0A;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.done_i = 32'd0;
        bus.pass_i = 32'd0;
        bus.test_num_i = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for a start bit and samples every bit in its middle.
    task automatic get_byte(output logic [7:0] b, output int sedge, output logic ok);
        ok = 1'b0;
        b = 8'h00;
        sedge = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.uart_tx_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sedge = cyc;
            repeat (5) @(negedge clk);
            check("start_mid", {31'd0, bus.uart_tx_o}, 32'd0);
            for (int j = 0; j < 8; j++) begin
                repeat (10) @(negedge clk);
                b[j] = bus.uart_tx_o;
            end
            repeat (10) @(negedge clk);
            check("stop_mid", {31'd0, bus.uart_tx_o}, 32'd1);
        end
    endtask

    task automatic run_msg(input string tag, input int t_zero, input logic exp_res);
        logic [7:0] b;
        int   se;
        logic ok;
        logic got;
        for (int i = 0; i < exp_len; i++) begin
            get_byte(b, se, ok);
            if (!ok) begin
                check($sformatf("%s_start_timeout_b%0d", tag, i), 32'd0, 32'd1);
                return;
            end
            check($sformatf("%s_byte%0d", tag, i), {24'd0, b}, {24'd0, exp_msg[i]});
            check($sformatf("%s_start_time%0d", tag, i), se - t_zero, 11 + 100 * i);
            check($sformatf("%s_busy%0d", tag, i), {31'd0, bus.busy_o}, 32'd1);
        end
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.report_done_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check($sformatf("%s_report_done_timeout", tag), 32'd0, 32'd1);
            return;
        end
        check($sformatf("%s_done_time", tag), cyc - t_zero, 11 + 100 * exp_len);
        check($sformatf("%s_busy_end", tag), {31'd0, bus.busy_o}, 32'd0);
        check($sformatf("%s_result", tag), {31'd0, bus.result_o}, {31'd0, exp_res});
        check($sformatf("%s_tx_idle", tag), {31'd0, bus.uart_tx_o}, 32'd1);
    endtask

    initial begin
        bus.done_i = 32'd0;
        bus.pass_i = 32'd0;
        bus.test_num_i = 32'd0;

        // 1: reset state and idle with done_i = 0
        repeat (2) @(negedge clk);
        check("reset_outputs", {28'd0, bus.uart_tx_o, bus.busy_o, bus.report_done_o, bus.result_o}, 32'h8);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_done0", {28'd0, bus.uart_tx_o, bus.busy_o, bus.report_done_o, bus.result_o}, 32'h8);
        end

        // 2: PASS message
        set_pass_msg();
        bus.done_i = 32'd1;
        bus.pass_i = 32'd1;
        t0 = cyc + 1;
        run_msg("pass", t0, 1'b1);

        // 3: FAIL 2A message
        do_reset();
        exp_len = 9;
        exp_msg[0] = 8'h46; exp_msg[1] = 8'h41; exp_msg[2] = 8'h49;
        exp_msg[3] = 8'h4C; exp_msg[4] = 8'h20; exp_msg[5] = 8'h32;
        exp_msg[6] = 8'h41; exp_msg[7] = 8'h0D; exp_msg[8] = 8'h0A;
        bus.done_i = 32'd1;
        bus.pass_i = 32'd0;
        bus.test_num_i = 32'h0000012A;
        t0 = cyc + 1;
        run_msg("fail", t0, 1'b0);

        // 4: pass_i sampled at T0+10 only
        do_reset();
        set_pass_msg();
        bus.done_i = 32'd1;
        bus.pass_i = 32'd0;
        t0 = cyc + 1;
        repeat (5) @(negedge clk);
        bus.pass_i = 32'd1;
        repeat (6) @(negedge clk);
        bus.pass_i = 32'd0;
        run_msg("late_pass", t0, 1'b1);

        // 5: done_i = 2 ignored, one-cycle pulse sends once, later pulse ignored
        do_reset();
        set_pass_msg();
        bus.done_i = 32'd2;
        bus.pass_i = 32'd1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("done2_ignored", {30'd0, bus.uart_tx_o, bus.busy_o}, 32'h2);
        end
        bus.done_i = 32'd1;
        t0 = cyc + 1;
        @(negedge clk);
        bus.done_i = 32'd0;
        run_msg("pulse", t0, 1'b1);
        @(negedge clk);
        bus.done_i = 32'd1;
        @(negedge clk);
        bus.done_i = 32'd0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("after_done_quiet", {29'd0, bus.uart_tx_o, bus.busy_o, bus.report_done_o}, 32'h5);
        end

        // 6: asynchronous reset mid-byte 3, then full restart
        do_reset();
        set_pass_msg();
        bus.done_i = 32'd1;
        bus.pass_i = 32'd1;
        t0 = cyc + 1;
        repeat (314) @(negedge clk);
        check("mid_byte3_low", {31'd0, bus.uart_tx_o}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, bus.uart_tx_o}, 32'd1);
        check("async_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc + 1;
        run_msg("restart", t0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/test_result_uart_tx.md
Name: test_result_uart_tx

Overview:
- Synthesizable hardware counterpart to the simulation pass/fail check on the RISC-V core's riscv-tests convention.
- Watches the core's completion flag (x26), pass flag (x27) and test number (x3), exported as ports from the regfile.
- Serialises a one-shot ASCII result message over an 8N1 UART TX line so FPGA runs report without a simulator.
- Sits beside risc_v_cpu at board top level; one report per reset.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD, integer-truncated (434 at defaults)
SETTLE_CYCLES, 10, clocks waited after done before sampling pass/test number (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
done_i  input  32  x26 value; test finished when exactly 32'd1
pass_i  input  32  x27 value; pass when exactly 32'd1
test_num_i  input  32  x3 value; low byte reported on fail
uart_tx_o  output  1  serial line, idle high
busy_o  output  1  high from done detection until last stop bit ends
report_done_o  output  1  high once message fully sent; held until reset
result_o  output  1  latched verdict, 1 = pass; valid when report_done_o = 1

Behaviour:
- Reset values: uart_tx_o=1, busy_o=0, report_done_o=0, result_o=0, FSM=IDLE, all counters 0. Reset takes effect asynchronously; uart_tx_o returns high immediately, even mid-bit.
- FSM states: IDLE -> SETTLE -> SEND -> DONE.
- IDLE: compare done_i == 32'd1 every edge; any other value, including 0 and 2, is ignored.
  - On the match edge (T0): enter SETTLE, busy_o=1, clear settle counter.
- SETTLE: count SETTLE_CYCLES clocks. done_i is no longer observed; a drop does not abort.
  - At edge T0+SETTLE_CYCLES: latch result_o = (pass_i == 32'd1) and tnum = test_num_i[7:0], then enter SEND.
- SEND: uart_tx_o falls (start bit) at edge T0+SETTLE_CYCLES+1.
  - Message on pass (6 bytes): "PASS\r\n" = 50 41 53 53 0D 0A.
  - Message on fail (9 bytes): "FAIL " + two uppercase hex digits of tnum (high nibble first) + "\r\n".
  - Hex mapping: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
  - Frame per byte: start 0, 8 data bits LSB first, stop 1. Each bit lasts exactly BAUD_DIV clocks; a byte is 10*BAUD_DIV clocks.
  - Bytes are back-to-back: the next start bit immediately follows the previous stop bit.
  - Byte-index counter 0..N-1; message byte chosen combinationally from index and verdict.
- Message end: after the last stop bit completes, enter DONE on the same edge. busy_o drops and report_done_o rises there.
  - Total SEND duration is N*10*BAUD_DIV clocks (N = 6 or 9).
- DONE: uart_tx_o=1, report_done_o=1, result_o held. No further transmission regardless of inputs until reset.
- Inputs are synchronous to clk (same domain as core); no synchronisers.
- Reset mid-operation: all state cleared. If done_i is still 1 after release, the full message restarts from byte 0 after a fresh settle.
- done_i already 1 at reset release: the first clock edge after release is T0.

Test Plan:
1. Reset (CLK_FREQ=1000, BAUD=100, DIV=10, SETTLE_CYCLES=10), done_i=0 for 50 cycles -> uart_tx_o=1, busy_o=0, report_done_o=0, result_o=0 throughout.
2. done_i=1, pass_i=1 -> start bit at T0+11; decoded bytes 50 41 53 53 0D 0A; each bit 10 clocks; busy_o high 611 cycles from T0 (11 settle/start offset + 600 frame); then report_done_o=1, result_o=1.
3. done_i=1, pass_i=0, test_num_i=32'h0000012A -> bytes 46 41 49 4C 20 32 41 0D 0A ("FAIL 2A\r\n"); result_o=0; 900-cycle frame.
4. pass_i=0 at T0, changed to 1 at T0+5, reverts to 0 at T0+11 -> value at T0+10 wins; PASS message sent.
5. done_i=2 for 100 cycles -> no start bit. Then done_i=1 for one cycle only -> full message sent once. A second done_i=1 pulse after DONE -> ignored.
6. rst asserted mid-byte 3 of PASS message while uart_tx_o=0 -> uart_tx_o=1 same cycle. After release with done_i=1 -> fresh settle, then complete 6-byte message from "P".
